// File: rtl/morra_cinese_n_if.sv
// Move/result bundle for the morra cinese arbiter.
// The player side drives the moves; the arbiter drives results and scores.
interface morra_cinese_n_if #(
  parameter int CNT_W = 5
);
  logic [1:0]       primo;
  logic [1:0]       secondo;
  logic [1:0]       manche;
  logic [1:0]       partita;
  logic [CNT_W-1:0] punti1;
  logic [CNT_W-1:0] punti2;
  logic [CNT_W-1:0] giocate;

  modport master (
    output primo, secondo,
    input  manche, partita, punti1, punti2, giocate
  );

  modport slave (
    input  primo, secondo,
    output manche, partita, punti1, punti2, giocate
  );
endinterface

// File: rtl/morra_cinese_n.sv
// Rock-paper-scissors match arbiter.
// One manche is sampled per cycle while the partita runs; a player may not
// repeat the move that last won for them. The partita ends on a sufficient
// lead after a minimum number of manches, or when the manche cap is reached.
module morra_cinese_n #(
  parameter int MIN_MANCHE = 4,
  parameter int MAX_BASE   = 4,
  parameter int VANT_WIN   = 2,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             inizio,
  morra_cinese_n_if.slave  bus
);

  typedef enum logic {GIOCO = 1'b0, FINE = 1'b1} state_t;

  state_t           r_state;
  logic [1:0]       r_manche;
  logic [1:0]       r_partita;
  logic [CNT_W-1:0] r_p1;
  logic [CNT_W-1:0] r_p2;
  logic [CNT_W-1:0] r_gio;
  logic [CNT_W-1:0] r_max;
  logic [1:0]       r_old1;
  logic [1:0]       r_old2;

  logic             w_valid;
  logic             w_draw;
  logic             w_p1win;
  logic             w_p2win;
  logic [1:0]       w_res;
  logic [CNT_W-1:0] w_p1n;
  logic [CNT_W-1:0] w_p2n;
  logic [CNT_W-1:0] w_gn;
  logic [CNT_W-1:0] w_lead;
  logic             w_end;
  logic [1:0]       w_partita;

  // Manche validity: both players moved and neither replayed a stored winning move.
  assign w_valid = (bus.primo != 2'b00) && (bus.secondo != 2'b00) &&
                   !((r_old1 != 2'b00) && (bus.primo   == r_old1)) &&
                   !((r_old2 != 2'b00) && (bus.secondo == r_old2));

  // Outcome: carta beats sasso, sasso beats forbice, forbice beats carta.
  assign w_draw  = (bus.primo == bus.secondo);
  assign w_p1win = ((bus.primo == 2'b10) && (bus.secondo == 2'b01)) ||
                   ((bus.primo == 2'b01) && (bus.secondo == 2'b11)) ||
                   ((bus.primo == 2'b11) && (bus.secondo == 2'b10));
  assign w_p2win = !w_draw && !w_p1win;
  assign w_res   = w_draw ? 2'b11 : (w_p1win ? 2'b01 : 2'b10);

  // Post-update counts, so the end test sees this manche's effect.
  assign w_p1n  = r_p1 + CNT_W'(w_p1win);
  assign w_p2n  = r_p2 + CNT_W'(w_p2win);
  assign w_gn   = r_gio + CNT_W'(1);
  assign w_lead = (w_p1n >= w_p2n) ? (w_p1n - w_p2n) : (w_p2n - w_p1n);
  assign w_end  = ((w_gn >= CNT_W'(MIN_MANCHE)) && (w_lead >= CNT_W'(VANT_WIN))) ||
                  (w_gn == r_max);
  assign w_partita = (w_p1n > w_p2n) ? 2'b01 :
                     (w_p2n > w_p1n) ? 2'b10 : 2'b11;

  // Partita FSM with registered results; inizio restarts from any state.
  always_ff @(posedge clk) begin
    if (inizio) begin
      r_max     <= CNT_W'(MAX_BASE) + CNT_W'({bus.primo, bus.secondo});
      r_state   <= GIOCO;
      r_manche  <= 2'b00;
      r_partita <= 2'b00;
      r_p1      <= '0;
      r_p2      <= '0;
      r_gio     <= '0;
      r_old1    <= 2'b00;
      r_old2    <= 2'b00;
    end else begin
      case (r_state)
        GIOCO: begin
          if (w_valid) begin
            r_manche <= w_res;
            r_p1     <= w_p1n;
            r_p2     <= w_p2n;
            r_gio    <= w_gn;
            if (w_p1win) begin
              r_old1 <= bus.primo;
              r_old2 <= 2'b00;
            end else if (w_p2win) begin
              r_old1 <= 2'b00;
              r_old2 <= bus.secondo;
            end else begin
              r_old1 <= 2'b00;
              r_old2 <= 2'b00;
            end
            if (w_end) begin
              r_partita <= w_partita;
              r_state   <= FINE;
            end
          end else begin
            r_manche <= 2'b00;
          end
        end
        FINE: r_manche <= 2'b00;
        default: r_state <= GIOCO;
      endcase
    end
  end

  assign bus.manche  = r_manche;
  assign bus.partita = r_partita;
  assign bus.punti1  = r_p1;
  assign bus.punti2  = r_p2;
  assign bus.giocate = r_gio;

endmodule

// File: tb/tb_morra_cinese_n.sv
// Bench for morra_cinese_n: directed scenarios plus a randomized run, all
// checked against a rule-level reference model of the game.
module tb_morra_cinese_n;
  localparam int CNT_W = 5;

  logic clk = 1'b0;
  logic inizio = 1'b0;
  always #5 clk = ~clk;

  morra_cinese_n_if #(.CNT_W(CNT_W)) bus ();

  morra_cinese_n #(
    .MIN_MANCHE(4), .MAX_BASE(4), .VANT_WIN(2), .CNT_W(CNT_W)
  ) dut (
    .clk    (clk),
    .inizio (inizio),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state (plain integers)
  int m_max, m_p1, m_p2, m_g, m_o1, m_o2, m_manche, m_partita;
  bit m_fine;

  function automatic void model_start(int p, int s);
    m_max = 4 + p * 4 + s;
    m_p1 = 0; m_p2 = 0; m_g = 0; m_o1 = 0; m_o2 = 0;
    m_manche = 0; m_partita = 0; m_fine = 0;
  endfunction

  function automatic void model_play(int p, int s);
    int r, lead;
    if (m_fine) begin m_manche = 0; return; end
    if (p == 0 || s == 0 || (m_o1 != 0 && p == m_o1) || (m_o2 != 0 && s == m_o2)) begin
      m_manche = 0;
      return;
    end
    // sasso=1, carta=2, forbice=3: each move beats the one just below it, cyclically
    r = (p - s + 3) % 3;
    m_g++;
    if (r == 0) begin m_manche = 3; m_o1 = 0; m_o2 = 0; end
    else if (r == 1) begin m_manche = 1; m_p1++; m_o1 = p; m_o2 = 0; end
    else begin m_manche = 2; m_p2++; m_o2 = s; m_o1 = 0; end
    lead = (m_p1 > m_p2) ? m_p1 - m_p2 : m_p2 - m_p1;
    if ((m_g >= 4 && lead >= 2) || m_g == m_max) begin
      m_fine = 1;
      m_partita = (m_p1 > m_p2) ? 1 : (m_p2 > m_p1) ? 2 : 3;
    end
  endfunction

  function automatic logic [18:0] m_vec();
    return {m_manche[1:0], m_partita[1:0], m_p1[4:0], m_p2[4:0], m_g[4:0]};
  endfunction

  function automatic logic [18:0] d_vec();
    return {bus.manche, bus.partita, bus.punti1, bus.punti2, bus.giocate};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start(int p, int s);
    inizio = 1'b1; bus.primo = 2'(p); bus.secondo = 2'(s);
    tick();
    inizio = 1'b0; bus.primo = 2'b00; bus.secondo = 2'b00;
    model_start(p, s);
  endtask

  task automatic play(int p, int s);
    bus.primo = 2'(p); bus.secondo = 2'(s);
    tick();
    model_play(p, s);
  endtask

  task automatic test_reset();
    bus.primo = 2'b00; bus.secondo = 2'b00;
    start(0, 0);
    checks++;
    if (d_vec() !== 19'd0) begin
      errors++; $display("FAIL reset_state got=%h exp=0", d_vec());
    end
  endtask

  task automatic test_draws();
    int mv [4] = '{1, 2, 3, 1};
    start(0, 0);
    foreach (mv[i]) begin
      play(mv[i], mv[i]);
      checks++;
      if (bus.manche !== 2'b11) begin
        errors++; $display("FAIL draw_manche[%0d] got=%b exp=11", i, bus.manche);
      end
    end
    checks++;
    if (bus.partita !== 2'b11 || bus.giocate !== 5'd4) begin
      errors++; $display("FAIL draw_end partita=%b giocate=%0d exp=11/4", bus.partita, bus.giocate);
    end
  endtask

  task automatic test_p1_wins();
    int pp [4] = '{2, 1, 3, 2};
    int ss [4] = '{1, 3, 2, 1};
    start(3, 3);
    for (int i = 0; i < 3; i++) play(pp[i], ss[i]);
    checks++;
    if (bus.partita !== 2'b00 || bus.punti1 !== 5'd3) begin
      errors++; $display("FAIL p1_mid partita=%b punti1=%0d exp=00/3", bus.partita, bus.punti1);
    end
    play(pp[3], ss[3]);
    checks++;
    if (bus.partita !== 2'b01 || bus.giocate !== 5'd4 || bus.manche !== 2'b01) begin
      errors++; $display("FAIL p1_end partita=%b giocate=%0d manche=%b exp=01/4/01",
                         bus.partita, bus.giocate, bus.manche);
    end
  endtask

  task automatic test_repeat();
    start(3, 3);
    play(2, 1);
    play(2, 3);
    checks++;
    if (bus.manche !== 2'b00 || bus.giocate !== 5'd1) begin
      errors++; $display("FAIL repeat_block manche=%b giocate=%0d exp=00/1", bus.manche, bus.giocate);
    end
    play(1, 3);
    checks++;
    if (bus.manche !== 2'b01 || bus.giocate !== 5'd2) begin
      errors++; $display("FAIL repeat_next manche=%b giocate=%0d exp=01/2", bus.manche, bus.giocate);
    end
  endtask

  task automatic test_invalid();
    start(3, 3);
    play(2, 1);
    play(0, 2);
    checks++;
    if (d_vec() !== m_vec() || bus.giocate !== 5'd1) begin
      errors++; $display("FAIL invalid_p1none got=%h exp=%h", d_vec(), m_vec());
    end
    play(1, 0);
    checks++;
    if (d_vec() !== m_vec() || bus.manche !== 2'b00) begin
      errors++; $display("FAIL invalid_p2none got=%h exp=%h", d_vec(), m_vec());
    end
  endtask

  task automatic test_restart();
    start(0, 0);
    play(2, 1);
    play(1, 2);
    start(0, 1);
    checks++;
    if (d_vec() !== 19'd0) begin
      errors++; $display("FAIL restart_clear got=%h exp=0", d_vec());
    end
    // new cap is 5: five draws end the partita exactly on the 5th
    for (int i = 0; i < 5; i++) begin
      play(i % 3 + 1, i % 3 + 1);
      checks++;
      if (bus.partita !== ((i == 4) ? 2'b11 : 2'b00)) begin
        errors++; $display("FAIL restart_max[%0d] partita=%b", i, bus.partita);
      end
    end
  endtask

  task automatic test_fine_hold();
    logic [18:0] held;
    start(0, 0);
    play(2, 1); play(1, 3); play(3, 2); play(2, 1);
    held = {2'b00, d_vec()[16:0]};
    for (int i = 0; i < 5; i++) begin
      play($urandom_range(1, 3), $urandom_range(1, 3));
      checks++;
      if (d_vec() !== held || d_vec() !== m_vec()) begin
        errors++; $display("FAIL fine_hold[%0d] got=%h exp=%h", i, d_vec(), held);
      end
    end
    start(0, 0);
    play(1, 2);
    checks++;
    if (d_vec() !== m_vec()) begin
      errors++; $display("FAIL fine_restart got=%h exp=%h", d_vec(), m_vec());
    end
  endtask

  task automatic test_random();
    int p, s;
    start($urandom_range(0, 3), $urandom_range(0, 3));
    for (int i = 0; i < 600; i++) begin
      p = $urandom_range(0, 7); p = (p > 3) ? $urandom_range(1, 3) : p;
      s = $urandom_range(0, 7); s = (s > 3) ? $urandom_range(1, 3) : s;
      if ($urandom_range(0, 15) == 0) begin
        start(p, s);
      end else begin
        play(p, s);
      end
      checks++;
      if (d_vec() !== m_vec()) begin
        errors++; $display("FAIL random[%0d] in=(%0d,%0d) got=%h exp=%h", i, p, s, d_vec(), m_vec());
      end
      checks++;
      if (int'(bus.giocate) > m_max) begin
        errors++; $display("FAIL random_cap[%0d] giocate=%0d max=%0d", i, bus.giocate, m_max);
      end
    end
  endtask

  initial begin
    bus.primo = 2'b00; bus.secondo = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_draws();
    test_p1_wins();
    test_repeat();
    test_invalid();
    test_restart();
    test_fine_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
